// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the 8-source round-robin mux arbiter slice.
//   - arb_state_t : FSM encoding (ST_IDLE / ST_GRANT)
//   - N_SRC, SEL_W: number of sources and select width
//   - MAX_HOLD_DEF, HOLD_W_DEF: default tenure limit and tenure counter width
//   - sel_onehot(): select index -> one-hot grant vector
// No ports (package).
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int N_SRC        = 8;
  localparam int SEL_W        = 3;
  localparam int MAX_HOLD_DEF = 4;
  localparam int HOLD_W_DEF   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_8x1.sv
// ---------------------------------------------------------------------------
// mux_8x1
// Plain combinational 8:1 single-bit multiplexer; the shared data path.
// Ports:
//   I  in  8  data bit per source
//   S  in  3  select index
//   Y  out 1  I[S]
// ---------------------------------------------------------------------------
module mux_8x1
  import mux_arb_pkg::*;
(
  input  logic [N_SRC-1:0] I,
  input  logic [SEL_W-1:0] S,
  output logic             Y
);

  assign Y = I[S];

endmodule

// File: rtl/mux_rr_pick.sv
// ---------------------------------------------------------------------------
// mux_rr_pick
// Combinational round-robin search: first requester at or after ptr,
// wrapping 7 -> 0.
// Ports:
//   req   in  8  request vector, bit i = source i
//   ptr   in  3  search start index
//   pick  out 3  index of the selected requester (don't care when any=0)
//   any   out 1  at least one request present
// ---------------------------------------------------------------------------
module mux_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [N_SRC-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so the source at ptr lands on bit 0; the lowest set bit of rot is
  // then the distance from ptr to the winner.
  assign rot = N_SRC'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  // Un-rotate: 3-bit addition wraps modulo 8.
  assign pick = ptr + off;
  assign any  = |req;

endmodule

// File: rtl/mux_8x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_8x1_rr_arbiter
// Round-robin arbiter sharing one 8:1 single-bit mux channel between eight
// requesters, with a bounded grant tenure of MAX_HOLD cycles.
//
// Build option: define ARB_LOCK_EN to add the lock input. While lock=1 in
// GRANT the tenure-end release is held off (counter saturates); a dropped
// request still releases. Without ARB_LOCK_EN there is no lock port.
//
// Parameters:
//   MAX_HOLD  max consecutive cycles one requester may hold the grant (1..7)
//   HOLD_W    tenure counter width, 2**HOLD_W > MAX_HOLD
// Ports:
//   clk    in   1  clock, all state on posedge
//   rst_n  in   1  synchronous active-low reset
//   req    in   8  request per source
//   I      in   8  data bit per source
//   lock   in   1  hold current grant past MAX_HOLD (ARB_LOCK_EN only)
//   S      out  3  registered select, index of current/last grantee
//   gnt    out  8  registered one-hot grant, zero when idle
//   Y      out  1  I[S] through mux_8x1
//   valid  out  1  |gnt
// ---------------------------------------------------------------------------
module mux_8x1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] I,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] S,
  output logic [N_SRC-1:0] gnt,
  output logic             Y,
  output logic             valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [HOLD_W-1:0] cnt;

  logic             lock_eff;
  logic [SEL_W-1:0] search_base;
  logic [SEL_W-1:0] pick;
  logic             any;
  logic             tenure_end;
  logic             release_now;

`ifdef ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  // In GRANT the search must already use the post-release pointer (S+1) so a
  // back-to-back grant needs no idle cycle. In IDLE ptr already equals that.
  assign search_base = (state == ST_GRANT) ? (S + SEL_W'(1)) : ptr;

  mux_rr_pick u_pick (
    .req  (req),
    .ptr  (search_base),
    .pick (pick),
    .any  (any)
  );

  assign tenure_end  = (cnt == HOLD_LAST) && !lock_eff;
  assign release_now = !req[S] || tenure_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      S     <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            state <= ST_GRANT;
            gnt   <= sel_onehot(pick);
            S     <= pick;
            cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            ptr <= S + SEL_W'(1);
            cnt <= '0;
            if (any) begin
              gnt <= sel_onehot(pick);
              S   <= pick;
            end else begin
              // S is left alone so Y stays stable while idle.
              state <= ST_IDLE;
              gnt   <= '0;
            end
          end else if (cnt < HOLD_LAST) begin
            cnt <= cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign valid = |gnt;

  mux_8x1 u_mux (
    .I (I),
    .S (S),
    .Y (Y)
  );

endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
module tb_mux_8x1_rr_arbiter;

  localparam int MH = 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_FEAT = 1'b1;
`else
  localparam bit LOCK_FEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] I = '0;
  logic [7:0] gnt;
  logic [2:0] S;
  logic       Y;
  logic       valid;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  mux_8x1_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .I     (I),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .S     (S),
    .gnt   (gnt),
    .Y     (Y),
    .valid (valid)
  );

  // ---------------- reference model (integer owner / tenure count) -------
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_ten = 0;

  function automatic int rr_search(input int start, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (start + k) % 8;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_ten = 0;
    end else if (!m_busy) begin
      if (req != 8'h00) begin
        m_owner = rr_search(m_ptr, req);
        m_busy  = 1'b1;
        m_ten   = 1;
      end
    end else if (!req[m_owner] || (m_ten >= MH && !(LOCK_FEAT && lock))) begin
      m_ptr = (m_owner + 1) % 8;
      if (req != 8'h00) begin
        m_owner = rr_search(m_ptr, req);
        m_ten   = 1;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_ten++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string nm, input logic [7:0] eg, input logic [2:0] es,
                            input logic ev);
    chk({nm, ".gnt"}, gnt, eg);
    chk({nm, ".S"}, S, es);
    chk({nm, ".valid"}, valid, ev);
    if (ev) chk({nm, ".Y"}, Y, I[es]);
  endtask

  task automatic chk_model(input string nm);
    logic [7:0] eg;
    eg = m_busy ? (8'h01 << m_owner) : 8'h00;
    chk({nm, ".gnt"}, gnt, eg);
    chk({nm, ".valid"}, valid, m_busy);
    if (m_busy) begin
      chk({nm, ".S"}, S, m_owner);
      chk({nm, ".Y"}, Y, I[m_owner]);
    end
  endtask

  task automatic hs_reset(input string nm);
    rst_n = 1'b0; req = 8'h00; lock = 1'b0;
    tick(); tick();
    expect_out(nm, 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Cycle invariants.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_valid", valid, |gnt);
    end
  end

  // ---------------- table vectors ----------------------------------------
  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       valid;
    logic       y;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic r, input logic [7:0] q, input logic [7:0] i,
                         input logic [7:0] g, input logic [2:0] s, input logic v);
    vec_t e;
    e.rst_n = r; e.req = q; e.i = i; e.gnt = g; e.s = s; e.valid = v;
    e.y = v ? i[s] : 1'b0;
    tbl.push_back(e);
  endtask

  initial begin
    logic [7:0] pat;
    int src;

    // Reset held with all requesting, then every source owns 4 cycles in turn.
    add_vec(1'b0, 8'hFF, 8'hA5, 8'h00, 3'd0, 1'b0);
    add_vec(1'b0, 8'hFF, 8'hA5, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 36; k++) begin
      src = (k / MH) % 8;
      pat = 8'hA5 ^ 8'(k * 37);
      add_vec(1'b1, 8'hFF, pat, 8'h01 << src, 3'(src), 1'b1);
    end

    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n; req = tbl[k].req; I = tbl[k].i; lock = 1'b0;
      tick();
      mon_on = 1'b1;
      chk($sformatf("tbl%0d.gnt", k), gnt, tbl[k].gnt);
      chk($sformatf("tbl%0d.S", k), S, tbl[k].s);
      chk($sformatf("tbl%0d.valid", k), valid, tbl[k].valid);
      if (tbl[k].valid) chk($sformatf("tbl%0d.Y", k), Y, tbl[k].y);
    end

    // Early drop: 2 owns 2 cycles, then 5 without an idle gap, then idle.
    hs_reset("drop_rst");
    req = 8'h24; I = 8'h24;
    tick(); expect_out("drop_c0", 8'h04, 3'd2, 1'b1);
    tick(); expect_out("drop_c1", 8'h04, 3'd2, 1'b1);
    req = 8'h20;
    tick(); expect_out("drop_c2", 8'h20, 3'd5, 1'b1);
    tick(); expect_out("drop_c3", 8'h20, 3'd5, 1'b1);
    req = 8'h00;
    tick(); expect_out("drop_idle", 8'h00, 3'd5, 1'b0);

    // Sole requester: tenure expiry re-grants at once, grant never gaps.
    hs_reset("sole_rst");
    req = 8'h08; I = 8'h08;
    for (int k = 0; k < 12; k++) begin
      tick(); expect_out($sformatf("sole_c%0d", k), 8'h08, 3'd3, 1'b1);
    end
    chk("sole_y_high", Y, 1'b1);
    I = 8'hF7; #1;
    chk("sole_y_low", Y, 1'b0);

    // Idle return keeps S; next search starts at 5 and wraps to source 0.
    hs_reset("idle_rst");
    req = 8'h10; I = 8'h5A;
    tick(); expect_out("idle_g4", 8'h10, 3'd4, 1'b1);
    req = 8'h00;
    tick(); expect_out("idle_0", 8'h00, 3'd4, 1'b0);
    tick(); expect_out("idle_1", 8'h00, 3'd4, 1'b0);
    req = 8'h11;
    tick(); expect_out("idle_wrap", 8'h01, 3'd0, 1'b1);

    // A request arriving mid-grant waits for the tenure end; search wraps to 7.
    hs_reset("late_rst");
    req = 8'h01; I = 8'h81;
    tick(); expect_out("late_c0", 8'h01, 3'd0, 1'b1);
    req = 8'h81;
    for (int k = 1; k < MH; k++) begin
      tick(); expect_out($sformatf("late_c%0d", k), 8'h01, 3'd0, 1'b1);
    end
    tick(); expect_out("late_next", 8'h80, 3'd7, 1'b1);

`ifdef ARB_LOCK_EN
    hs_reset("lock_rst");
    req = 8'h03; lock = 1'b1; I = 8'h02;
    for (int k = 0; k < 8; k++) begin
      tick(); expect_out($sformatf("lock_c%0d", k), 8'h01, 3'd0, 1'b1);
    end
    lock = 1'b0;
    tick(); expect_out("lock_rel", 8'h02, 3'd1, 1'b1);
`endif

    // Randomised run against the reference model.
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 8'h00;
          1: req = 8'($urandom);
          2: req = 8'h01 << $urandom_range(0, 7);
          default: req = 8'hFF;
        endcase
      end
      I = 8'($urandom);
      lock = LOCK_FEAT && ($urandom_range(0, 3) == 0);
      tick();
      chk_model($sformatf("rnd%0d", n));
    end

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
